// File: rtl/traffic_gen_pkg.sv
// Shared types and LFSR constants for the traffic pattern generator.
package traffic_gen_pkg;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        MODE_UNIFORM  = 2'd0,
        MODE_HOTSPOT  = 2'd1,
        MODE_NEIGHBOR = 2'd2,
        MODE_SELF     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WMODE_READ   = 2'd0,
        WMODE_WRITE  = 2'd1,
        WMODE_ALT    = 2'd2,
        WMODE_RANDOM = 2'd3
    } wmode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_START  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // One Galois right-shift step.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/traffic_pattern_gen_lfsr16.sv
// Per-channel 16-bit Galois LFSR; step wins over load, zero seed maps to 1.
module lfsr16
    import traffic_gen_pkg::*;
(
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load,
    input  logic                  step,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] value
);

    logic [LFSR_WIDTH-1:0] seed_nz;

    assign seed_nz = (seed == '0) ? LFSR_WIDTH'(1) : seed;

    always_ff @(posedge aclk) begin
        if (areset) begin
            value <= seed_nz;
        end else if (step) begin
            value <= lfsr_next(value);
        end else if (load) begin
            value <= seed_nz;
        end
    end

endmodule

// File: rtl/traffic_pattern_gen.sv
// Loader traffic generator: fills N command FIFOs in parallel, starts the
// loaders, then measures run length until all report idle or the run times out.
module traffic_pattern_gen
    import traffic_gen_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned TIMEOUT    = 65536,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          go_i,
    input  logic [1:0]    cfg_mode_i,
    input  logic [1:0]    cfg_wmode_i,
    input  logic [7:0]    cfg_txn_count_i,
    input  logic [7:0]    cfg_axlen_i,
    input  logic [4:0]    cfg_hotspot_i,
    input  logic          cfg_resp_wait_i,
    input  logic [N-1:0]  idle_i,
    output logic [4:0]    id_o [N],
    output logic [N-1:0]  write_o,
    output logic [7:0]    axlen_o [N],
    output logic [N-1:0]  fifo_push_o,
    output logic [N-1:0]  resp_wait_o,
    output logic          start_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [31:0]   cycles_o
);

    localparam int unsigned IDW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] UNI_MASK  = 16'((1 << IDW) - 1);
    localparam logic [7:0]  DEPTH_CAP = (FIFO_DEPTH > 255) ? 8'd255 : 8'(FIFO_DEPTH);

    state_e     state;
    mode_e      mode_q;
    wmode_e     wmode_q;
    logic [4:0] hot_q;
    logic [7:0] axlen_q;
    logic       alt_q;
    logic [7:0] push_cnt;
    logic [7:0] push_total;
    logic [1:0] settle_cnt;

    mode_e      cur_mode;
    wmode_e     cur_wmode;
    logic [4:0] cur_hot;
    logic [7:0] cur_axlen;
    logic       cur_alt;
    logic [4:0] hot_mod;
    logic [7:0] p_c;
    logic       issue;
    logic [31:0] cyc_next;

    logic [15:0] lfsr_val [N];
    logic [4:0]  dest [N];
    logic [N-1:0] wr;

    // The launch push uses live cfg inputs; later pushes use the latched copy.
    assign cur_mode  = (state == ST_IDLE) ? mode_e'(cfg_mode_i)   : mode_q;
    assign cur_wmode = (state == ST_IDLE) ? wmode_e'(cfg_wmode_i) : wmode_q;
    assign cur_hot   = (state == ST_IDLE) ? cfg_hotspot_i         : hot_q;
    assign cur_axlen = (state == ST_IDLE) ? cfg_axlen_i           : axlen_q;
    assign cur_alt   = (state == ST_IDLE) ? 1'b1                  : alt_q;
    assign hot_mod   = 5'(32'(cur_hot) % N);

    assign p_c      = (cfg_txn_count_i > DEPTH_CAP) ? DEPTH_CAP : cfg_txn_count_i;
    assign issue    = ((state == ST_IDLE) && go_i && (p_c != 8'd0)) ||
                      ((state == ST_FILL) && (push_cnt < push_total));
    assign cyc_next = (cycles_o == '1) ? cycles_o : cycles_o + 32'd1;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [15:0] raw;
        logic [15:0] uni;

        lfsr16 u_lfsr (
            .aclk   (aclk),
            .areset (areset),
            .load   (state != ST_FILL),
            .step   (issue),
            .seed   (SEED ^ 16'(i << 8)),
            .value  (lfsr_val[i])
        );

        assign raw = lfsr_val[i] & UNI_MASK;
        assign uni = (raw >= 16'(N)) ? raw - 16'(N) : raw;

        assign dest[i] = (cur_mode == MODE_UNIFORM)  ? 5'(uni) :
                         (cur_mode == MODE_HOTSPOT)  ? hot_mod :
                         (cur_mode == MODE_NEIGHBOR) ? 5'((i + 1) % N) : 5'(i);

        assign wr[i] = (cur_wmode == WMODE_WRITE) ||
                       ((cur_wmode == WMODE_ALT) && cur_alt) ||
                       ((cur_wmode == WMODE_RANDOM) && lfsr_val[i][15]);
    end

    // Sequencer with registered push bus and status.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_UNIFORM;
            wmode_q     <= WMODE_READ;
            hot_q       <= '0;
            axlen_q     <= '0;
            alt_q       <= 1'b0;
            push_cnt    <= '0;
            push_total  <= '0;
            settle_cnt  <= '0;
            write_o     <= '0;
            fifo_push_o <= '0;
            resp_wait_o <= '0;
            start_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            cycles_o    <= '0;
            for (int i = 0; i < int'(N); i++) begin
                id_o[i]    <= '0;
                axlen_o[i] <= '0;
            end
        end else begin
            fifo_push_o <= '0;
            write_o     <= '0;
            start_o     <= 1'b0;
            done_o      <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                id_o[i]    <= '0;
                axlen_o[i] <= '0;
            end

            if (issue) begin
                fifo_push_o <= '1;
                write_o     <= wr;
                alt_q       <= ~cur_alt;
                push_cnt    <= (state == ST_IDLE) ? 8'd1 : push_cnt + 8'd1;
                for (int i = 0; i < int'(N); i++) begin
                    id_o[i]    <= dest[i];
                    axlen_o[i] <= cur_axlen;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (go_i) begin
                        mode_q      <= mode_e'(cfg_mode_i);
                        wmode_q     <= wmode_e'(cfg_wmode_i);
                        hot_q       <= cfg_hotspot_i;
                        axlen_q     <= cfg_axlen_i;
                        resp_wait_o <= {N{cfg_resp_wait_i}};
                        push_total  <= p_c;
                        cycles_o    <= '0;
                        timeout_o   <= 1'b0;
                        busy_o      <= 1'b1;
                        if (p_c == 8'd0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (!issue) begin
                        state   <= ST_START;
                        start_o <= 1'b1;
                    end
                end
                ST_START: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    cycles_o   <= cyc_next;
                    settle_cnt <= settle_cnt + 2'd1;
                    if (settle_cnt == 2'd1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycles_o <= cyc_next;
                    if (&idle_i) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end else if (cyc_next >= 32'(TIMEOUT)) begin
                        state     <= ST_DONE;
                        done_o    <= 1'b1;
                        timeout_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_pattern_gen.sv
// Randomized self-checking bench for traffic_pattern_gen against a behavioural model.
module tb_traffic_pattern_gen;

    localparam int N     = 16;
    localparam int DEPTH = 64;
    localparam int TMO   = 100;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          go_i;
    logic [1:0]    cfg_mode_i;
    logic [1:0]    cfg_wmode_i;
    logic [7:0]    cfg_txn_count_i;
    logic [7:0]    cfg_axlen_i;
    logic [4:0]    cfg_hotspot_i;
    logic          cfg_resp_wait_i;
    logic [N-1:0]  idle_i;
    logic [4:0]    id_o [N];
    logic [N-1:0]  write_o;
    logic [7:0]    axlen_o [N];
    logic [N-1:0]  fifo_push_o;
    logic [N-1:0]  resp_wait_o;
    logic          start_o;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic [31:0]   cycles_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_lfsr [N];

    traffic_pattern_gen #(
        .N          (N),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .SEED       (SEED)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .go_i            (go_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_wmode_i     (cfg_wmode_i),
        .cfg_txn_count_i (cfg_txn_count_i),
        .cfg_axlen_i     (cfg_axlen_i),
        .cfg_hotspot_i   (cfg_hotspot_i),
        .cfg_resp_wait_i (cfg_resp_wait_i),
        .idle_i          (idle_i),
        .id_o            (id_o),
        .write_o         (write_o),
        .axlen_o         (axlen_o),
        .fifo_push_o     (fifo_push_o),
        .resp_wait_o     (resp_wait_o),
        .start_o         (start_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .timeout_o       (timeout_o),
        .cycles_o        (cycles_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic reseed();
        logic [15:0] s;
        for (int i = 0; i < N; i++) begin
            s = SEED ^ 16'(i * 256);
            model_lfsr[i] = (s == 16'd0) ? 16'd1 : s;
        end
    endtask

    function automatic int exp_dest(input int mode, input int ch, input logic [15:0] l, input int hot);
        int v;
        case (mode)
            0: begin
                v = int'(l) % (1 << $clog2(N));
                if (v >= N) v = v - N;
            end
            1: v = hot % N;
            2: v = (ch + 1) % N;
            default: v = ch;
        endcase
        return v;
    endfunction

    function automatic logic exp_write(input int wmode, input int j, input logic [15:0] l);
        case (wmode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (j % 2 == 0);
            default: return l[15];
        endcase
    endfunction

    function automatic bit any_output_set();
        bit r;
        r = (write_o !== '0) || (fifo_push_o !== '0) || (resp_wait_o !== '0) ||
            (start_o !== 1'b0) || (busy_o !== 1'b0) || (done_o !== 1'b0) ||
            (timeout_o !== 1'b0) || (cycles_o !== 32'd0);
        for (int i = 0; i < N; i++)
            if (id_o[i] !== 5'd0 || axlen_o[i] !== 8'd0) r = 1'b1;
        return r;
    endfunction

    function automatic bit push_bus_nonzero();
        bit r;
        r = (write_o !== '0) || (fifo_push_o !== '0);
        for (int i = 0; i < N; i++)
            if (id_o[i] !== 5'd0 || axlen_o[i] !== 8'd0) r = 1'b1;
        return r;
    endfunction

    // Full launch-to-idle run: idle_at = cycle index (0 = first SETTLE cycle) at
    // which all loaders go idle; -1 never; -2 means only loader 3 stays busy.
    task automatic run_scenario(input int mode, input int wmode, input int cnt, input int axlen,
                                input int hot, input bit rw, input int idle_at, input bit ping_go);
        int p, e_id, exit_c, to_c;
        logic e_wr;
        bit exp_to;
        p = (cnt > DEPTH) ? DEPTH : cnt;
        reseed();
        idle_i          = (idle_at == -2) ? ~16'h0008 : '0;
        cfg_mode_i      = 2'(mode);
        cfg_wmode_i     = 2'(wmode);
        cfg_txn_count_i = 8'(cnt);
        cfg_axlen_i     = 8'(axlen);
        cfg_hotspot_i   = 5'(hot);
        cfg_resp_wait_i = rw;
        go_i            = 1'b1;
        @(negedge aclk);
        go_i            = 1'b0;
        cfg_mode_i      = 2'($urandom);
        cfg_wmode_i     = 2'($urandom);
        cfg_txn_count_i = 8'($urandom);
        cfg_axlen_i     = 8'($urandom);
        cfg_hotspot_i   = 5'($urandom);
        cfg_resp_wait_i = 1'($urandom);

        if (p == 0) begin
            checks++;
            if (done_o !== 1'b1 || cycles_o !== 32'd0 || start_o !== 1'b0 || busy_o !== 1'b1 ||
                timeout_o !== 1'b0 || fifo_push_o !== '0) begin
                errors++;
                $display("FAIL zero_count_done: done=%b cycles=%0d start=%b busy=%b to=%b push=%h, need 1 0 0 1 0 0",
                         done_o, cycles_o, start_o, busy_o, timeout_o, fifo_push_o);
            end
            @(negedge aclk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || start_o !== 1'b0 || cycles_o !== 32'd0) begin
                errors++;
                $display("FAIL zero_count_after: done=%b busy=%b start=%b cycles=%0d, need 0 0 0 0",
                         done_o, busy_o, start_o, cycles_o);
            end
            return;
        end

        for (int j = 0; j < p; j++) begin
            go_i = (ping_go && j == 1);
            for (int c = 0; c < N; c++) begin
                e_id = exp_dest(mode, c, model_lfsr[c], hot);
                e_wr = exp_write(wmode, j, model_lfsr[c]);
                checks++;
                if (fifo_push_o[c] !== 1'b1 || id_o[c] !== 5'(e_id) || write_o[c] !== e_wr ||
                    axlen_o[c] !== 8'(axlen) || resp_wait_o[c] !== rw) begin
                    errors++;
                    $display("FAIL push ch%0d n%0d: got push=%b id=%0d wr=%b len=%0d rw=%b, need 1 id=%0d wr=%b len=%0d rw=%b",
                             c, j, fifo_push_o[c], id_o[c], write_o[c], axlen_o[c], resp_wait_o[c],
                             e_id, e_wr, axlen, rw);
                end
                model_lfsr[c] = galois(model_lfsr[c]);
            end
            checks++;
            if (start_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0 || cycles_o !== 32'd0 ||
                timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL fill_status n%0d: start=%b busy=%b done=%b cycles=%0d to=%b, need 0 1 0 0 0",
                         j, start_o, busy_o, done_o, cycles_o, timeout_o);
            end
            @(negedge aclk);
        end
        go_i = 1'b0;

        checks++;
        if (start_o !== 1'b1 || push_bus_nonzero() || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: start=%b push=%h busy=%b, need start=1 idle bus busy=1",
                     start_o, fifo_push_o, busy_o);
        end
        @(negedge aclk);

        to_c   = (TMO - 1 < 2) ? 2 : TMO - 1;
        exit_c = (idle_at >= 0) ? ((idle_at < 2) ? 2 : idle_at) : -1;
        exp_to = 1'b0;
        if (exit_c < 0 || exit_c > to_c) begin
            exit_c = to_c;
            exp_to = 1'b1;
        end
        for (int k = 0; k <= exit_c; k++) begin
            if (idle_at >= 0 && k == idle_at) idle_i = '1;
            checks++;
            if (busy_o !== 1'b1 || done_o !== 1'b0 || start_o !== 1'b0 || push_bus_nonzero()) begin
                errors++;
                $display("FAIL run_status c%0d: busy=%b done=%b start=%b push=%h, need 1 0 0 0",
                         k, busy_o, done_o, start_o, fifo_push_o);
            end
            @(negedge aclk);
        end

        checks++;
        if (done_o !== 1'b1 || cycles_o !== 32'(exit_c + 1) || timeout_o !== exp_to || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b cycles=%0d to=%b busy=%b, need 1 %0d %b 1",
                     done_o, cycles_o, timeout_o, busy_o, exit_c + 1, exp_to);
        end
        idle_i = '0;
        @(negedge aclk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== 32'(exit_c + 1) || timeout_o !== exp_to) begin
            errors++;
            $display("FAIL post_done: done=%b busy=%b cycles=%0d to=%b, need 0 0 %0d %b",
                     done_o, busy_o, cycles_o, timeout_o, exit_c + 1, exp_to);
        end
        @(negedge aclk);
        checks++;
        if (busy_o !== 1'b0 || cycles_o !== 32'(exit_c + 1) || timeout_o !== exp_to || start_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b cycles=%0d to=%b start=%b, need 0 %0d %b 0",
                     busy_o, cycles_o, timeout_o, start_o, exit_c + 1, exp_to);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        go_i = 1'b0;
        idle_i = '0;
        cfg_mode_i = '0; cfg_wmode_i = '0; cfg_txn_count_i = '0;
        cfg_axlen_i = '0; cfg_hotspot_i = '0; cfg_resp_wait_i = 1'b0;
        repeat (2) @(negedge aclk);
        checks++;
        if (any_output_set()) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b start=%b push=%h cycles=%0d, need all 0",
                     busy_o, done_o, start_o, fifo_push_o, cycles_o);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (any_output_set()) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b start=%b push=%h, need all 0",
                     busy_o, done_o, start_o, fifo_push_o);
        end
    endtask

    task automatic test_neighbor();
        run_scenario(2, 1, 3, 7, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_fifo_cap();
        run_scenario(0, 3, 200, 15, 0, 1'b1, 5, 1'b1);
    endtask

    task automatic test_hotspot_alternate();
        run_scenario(1, 2, 6, 1, 21, 1'b1, 3, 1'b0);
    endtask

    task automatic test_timeout();
        run_scenario(3, 0, 2, 0, 0, 1'b0, -2, 1'b0);
    endtask

    task automatic test_zero_count();
        run_scenario(0, 1, 0, 4, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_scenario(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(1, 20)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 12)),
                         1'($urandom));
        end
    endtask

    task automatic test_reset_in_run();
        cfg_mode_i = 2'd0; cfg_wmode_i = 2'd3; cfg_txn_count_i = 8'd5;
        cfg_axlen_i = 8'd3; cfg_hotspot_i = 5'd0; cfg_resp_wait_i = 1'b1;
        idle_i = '0;
        go_i = 1'b1;
        @(negedge aclk);
        go_i = 1'b0;
        repeat (11) @(negedge aclk);
        checks++;
        if (busy_o !== 1'b1 || fifo_push_o !== '0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL pre_abort: busy=%b push=%h done=%b, need 1 0 0", busy_o, fifo_push_o, done_o);
        end
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if (any_output_set()) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b start=%b push=%h cycles=%0d, need all 0",
                     busy_o, done_o, start_o, fifo_push_o, cycles_o);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (any_output_set()) begin
            errors++;
            $display("FAIL abort_release: busy=%b done=%b start=%b push=%h, need all 0",
                     busy_o, done_o, start_o, fifo_push_o);
        end
        run_scenario(0, 3, 5, 3, 0, 1'b1, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_neighbor();
        test_fifo_cap();
        test_hotspot_alternate();
        test_timeout();
        test_zero_count();
        test_random();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_pattern_gen.md
TRAFFIC_PATTERN_GEN -- requirements
Module: traffic_pattern_gen

Interface
REQ-001 Parameter N, 16: number of loader channels; N >= 2 and N <= 32.
REQ-002 Parameter FIFO_DEPTH, 64: loader command FIFO depth; sets the cap on pushes per channel.
REQ-003 Parameter TIMEOUT, 65536: maximum cycles allowed in RUN.
REQ-004 Parameter SEED, 16'hACE1: base LFSR seed.
REQ-005 aclk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 go_i  in  1  launch request; sampled only in IDLE.
REQ-008 cfg_mode_i  in  2  destination mode: 0 uniform, 1 hotspot, 2 neighbor, 3 self.
REQ-009 cfg_wmode_i  in  2  direction mode: 0 read, 1 write, 2 alternate, 3 random.
REQ-010 cfg_txn_count_i  in  8  transactions per channel.
REQ-011 cfg_axlen_i  in  8  AXI burst length applied to every transaction.
REQ-012 cfg_hotspot_i  in  5  hotspot destination.
REQ-013 cfg_resp_wait_i  in  1  value forwarded to every loader.
REQ-014 idle_i[N]  in  1 each  loader idle flags.
REQ-015 id_o[N], write_o[N], axlen_o[N], fifo_push_o[N], resp_wait_o[N]  out  5/1/8/1/1 each  per-loader command push bus.
REQ-016 start_o  out  1  loader start pulse.
REQ-017 busy_o, done_o, timeout_o  out  1 each  status outputs.
REQ-018 cycles_o  out  32  measured run length.

Function
REQ-019 The FSM SHALL implement the states IDLE, FILL, START, SETTLE, RUN and DONE.
REQ-020 When go_i is high in IDLE, the block SHALL latch all cfg_* inputs and enter FILL; the first fifo_push_o SHALL occur in the cycle after go_i is sampled.
REQ-021 The push count SHALL be P = min(cfg_txn_count_i, FIFO_DEPTH).
REQ-022 In FILL, all N channels SHALL push in parallel, one entry per cycle, for exactly P cycles, then the FSM SHALL go to START.
REQ-023 If P == 0, the FSM SHALL go from IDLE directly to DONE with cycles_o = 0 and no start_o pulse.
REQ-024 Destinations SHALL be computed as follows:
- Uniform: lfsr[k-1:0] with k = clog2(N); subtract N if the value is >= N.
- Hotspot: cfg_hotspot_i modulo N.
- Neighbor: (i+1) mod N.
- Self: i.
REQ-025 write_o SHALL be computed as follows:
- Read: 0.
- Write: 1.
- Alternate: toggles per push, first push is a write.
- Random: lfsr[15].
REQ-026 Each channel SHALL own one 16-bit Galois LFSR (mask 16'hB400) seeded SEED ^ (i << 8) in IDLE, advanced only on push; an all-zero seed SHALL be replaced by 16'h0001.
REQ-027 START SHALL assert start_o for exactly one cycle, then the FSM SHALL go to SETTLE.
REQ-028 SETTLE SHALL last 2 cycles, ignoring idle_i, then the FSM SHALL go to RUN.
REQ-029 RUN SHALL exit to DONE in the first cycle in which all idle_i are high.
REQ-030 RUN SHALL exit to DONE with timeout_o = 1 after TIMEOUT cycles.
REQ-031 cycles_o SHALL count the SETTLE and RUN cycles, including the exit cycle, saturating at 32'hFFFFFFFF.
REQ-032 cycles_o SHALL be cleared on go_i and held after DONE.
REQ-033 done_o SHALL pulse for one cycle in DONE, after which the FSM SHALL return to IDLE.
REQ-034 timeout_o SHALL hold until the next go_i.
REQ-035 busy_o SHALL be high in every state except IDLE.
REQ-036 go_i outside IDLE SHALL be ignored, and cfg_* changes mid-run SHALL have no effect.
REQ-037 fifo_push_o SHALL be high only in FILL.
REQ-038 id_o, write_o and axlen_o SHALL be zero whenever fifo_push_o is low.

Reset
REQ-039 On areset, the FSM SHALL enter IDLE and every output SHALL be 0.
REQ-040 On areset, the counters SHALL clear and the LFSRs SHALL reload their seeds.
REQ-041 Reset asserted in any state SHALL abort the operation within the same clock edge, with no start_o or done_o emitted.

Structure
REQ-042 Package traffic_gen_pkg SHALL hold the mode_e, wmode_e and state_e enums plus the LFSR_MASK and LFSR_WIDTH constants.
REQ-043 Sub-module lfsr16 (load, step, seed, value) SHALL be instantiated N times in a generate loop.
REQ-044 The block SHALL connect one-to-one to the loader command ports of the mesh cosim top, replacing external push drive.

Verification
REQ-045 Neighbor mode, N=16, count=3, write mode, axlen=7 -> 3 push cycles; channel 15 pushes id 0; start_o one cycle after the last push.
REQ-046 count=200, FIFO_DEPTH=64 -> exactly 64 push cycles per channel.
REQ-047 count=0 -> done_o the cycle after go_i; cycles_o=0; start_o never asserted.
REQ-048 Hotspot mode with hotspot=21, N=16 -> every id_o=5; alternate mode -> write_o sequence 1,0,1,...
REQ-049 idle_i[3] held low, TIMEOUT=100 -> done_o and timeout_o asserted with cycles_o=100 (SETTLE included); next go_i clears timeout_o.
REQ-050 areset asserted during RUN -> next cycle in IDLE with all outputs 0; a subsequent go_i reproduces the same LFSR sequence as the first run.
